// File: rtl/sdm_tdm_sched.sv
// Time-division shared first-order SDM section: NCH channels, per-channel
// integrator/quantizer bank, round-robin valid/ready grant, one registered result stream.
module sdm_tdm_sched #(
  parameter int W   = 10,
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 en,
  input  logic                 soft_clr,
  input  logic [NCH-1:0]       in_valid,
  input  logic [NCH*W-1:0]     in_data,
  output logic [NCH-1:0]       in_ready,
  output logic                 out_valid,
  output logic [CW-1:0]        out_ch,
  output logic [1:0]           out_q,
  output logic signed [W-1:0]  out_resid,
  output logic [NCH-1:0]       ovf,
  input  logic [NCH-1:0]       clr_ovf,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, RUN, CLR} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        clr_cnt, rr_ptr, gidx;
  logic [CW:0]          scan;
  logic                 gvalid, grant_en, xfer;
  logic signed [W-1:0]  acc [NCH];
  logic [NCH-1:0]       qreg;
  logic signed [W-1:0]  din [NCH];
  logic signed [W-1:0]  d, accg, sub, acc_n, resid;
  logic                 qg, q, ovf_hit;
  logic [NCH-1:0]       ovf_set;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (soft_clr) begin
      state_nxt = CLR;
    end else begin
      unique case (state)
        IDLE: if (en)  state_nxt = RUN;
        RUN:  if (!en) state_nxt = IDLE;
        CLR:  if (clr_cnt == CW'(NCH-1)) state_nxt = en ? RUN : IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy     = (state == CLR);
    grant_en = (state == RUN) && en && !soft_clr;
  end

  // Restarting on soft_clr covers both entry into CLR and a re-pulse during it
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)              clr_cnt <= '0;
    else if (soft_clr)      clr_cnt <= '0;
    else if (state == CLR)  clr_cnt <= clr_cnt + 1'b1;
  end

  // Round-robin search from rr_ptr upward, wrapping at NCH-1
  always_comb begin
    gvalid = 1'b0;
    gidx   = '0;
    scan   = '0;
    for (int unsigned off = 0; off < NCH; off++) begin
      scan = {1'b0, rr_ptr} + (CW+1)'(off);
      if (scan >= (CW+1)'(NCH)) scan = scan - (CW+1)'(NCH);
      if (!gvalid && in_valid[scan[CW-1:0]]) begin
        gvalid = 1'b1;
        gidx   = scan[CW-1:0];
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NCH; i++) din[i] = in_data[i*W +: W];
  end

  always_comb begin
    xfer = grant_en && gvalid;
    d    = din[gidx];
    accg = acc[gidx];
    qg   = qreg[gidx];
    sub   = d - {{(W-1){1'b0}}, qg};
    acc_n = accg + sub;
    q     = ~acc_n[W-1];
    resid = acc_n - {{(W-1){1'b0}}, q};
    ovf_hit = (d[W-1] & ~sub[W-1]) |
              ((sub[W-1] == accg[W-1]) & (acc_n[W-1] != sub[W-1]));
    in_ready = '0;
    ovf_set  = '0;
    if (xfer) begin
      in_ready[gidx] = 1'b1;
      ovf_set[gidx]  = ovf_hit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NCH; i++) acc[i] <= '0;
      qreg <= '0;
    end else if (state == CLR) begin
      acc[clr_cnt]  <= '0;
      qreg[clr_cnt] <= 1'b0;
    end else if (xfer) begin
      acc[gidx]  <= acc_n;
      qreg[gidx] <= q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr    <= '0;
      ovf       <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_q     <= '0;
      out_resid <= '0;
    end else begin
      ovf       <= (ovf & ~clr_ovf) | ovf_set;
      out_valid <= xfer;
      if (xfer) begin
        rr_ptr    <= (gidx == CW'(NCH-1)) ? '0 : gidx + 1'b1;
        out_ch    <= gidx;
        out_q     <= {1'b0, q};
        out_resid <= resid;
      end
    end
  end

endmodule

// File: tb/tb_sdm_tdm_sched.sv
// Self-checking bench for sdm_tdm_sched: directed scenarios plus randomized
// traffic, compared against an arithmetic reference model of the scheduler.
module tb_sdm_tdm_sched;
  localparam int W = 10, NCH = 4, CW = 2;

  logic                clk = 1'b0;
  logic                rstn, en, soft_clr, out_valid, busy;
  logic [NCH-1:0]      in_valid, in_ready, ovf, clr_ovf;
  logic [NCH*W-1:0]    in_data;
  logic [CW-1:0]       out_ch;
  logic [1:0]          out_q;
  logic signed [W-1:0] out_resid;

  int tests = 0, fails = 0;

  // Reference model state: mode 0 idle, 1 run, 2 clearing
  int             m_acc [NCH];
  int             m_q   [NCH];
  int             m_ptr, m_mode, m_cnt;
  logic [NCH-1:0] m_ovf;
  int             m_ov, m_och, m_oq, m_ores;

  always #5 clk = ~clk;

  sdm_tdm_sched #(.W(W), .NCH(NCH), .CW(CW)) dut (
    .clk(clk), .rstn(rstn), .en(en), .soft_clr(soft_clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ch(out_ch), .out_q(out_q),
    .out_resid(out_resid), .ovf(ovf), .clr_ovf(clr_ovf), .busy(busy)
  );

  function automatic int wrapw(input int x);
    int m;
    m = x & ((1 << W) - 1);
    if (m >= (1 << (W-1))) m = m - (1 << W);
    return m;
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input int v);
    in_data[ch*W +: W] = W'(v);
  endtask

  // One clock: check grant/busy before the edge, advance model, check outputs after
  task automatic cycle();
    int g, d, sub_t, sub, acc_t, accn, qn;
    logic [NCH-1:0] exp_rdy;
    logic signed [W-1:0] dv;
    #1;
    g = -1;
    if (m_mode == 1 && en && !soft_clr)
      for (int k = 0; k < NCH; k++) begin
        int idx;
        idx = (m_ptr + k) % NCH;
        if (g < 0 && in_valid[idx]) g = idx;
      end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    chk("in_ready", in_ready, exp_rdy);
    chk("busy", busy, m_mode == 2);
    @(posedge clk);
    m_ovf = m_ovf & ~clr_ovf;
    if (g >= 0) begin
      dv    = in_data[g*W +: W];
      d     = dv;
      sub_t = d - m_q[g];
      sub   = wrapw(sub_t);
      acc_t = m_acc[g] + sub;
      accn  = wrapw(acc_t);
      qn    = (accn < 0) ? 0 : 1;
      if (sub_t != sub || acc_t != accn) m_ovf[g] = 1'b1;
      m_acc[g] = accn;
      m_q[g]   = qn;
      m_ptr    = (g + 1) % NCH;
      m_ov = 1; m_och = g; m_oq = qn; m_ores = wrapw(accn - qn);
    end else begin
      m_ov = 0;
    end
    if (m_mode == 2) begin
      m_acc[m_cnt] = 0;
      m_q[m_cnt]   = 0;
    end
    if (soft_clr) begin
      m_mode = 2; m_cnt = 0;
    end else if (m_mode == 2) begin
      if (m_cnt == NCH-1) m_mode = en ? 1 : 0;
      else m_cnt++;
    end else begin
      m_mode = en ? 1 : 0;
    end
    #1;
    chk("out_valid", out_valid, m_ov);
    chk("out_ch", out_ch, m_och);
    chk("out_q", out_q, m_oq);
    chk("out_resid", out_resid, m_ores);
    chk("ovf", ovf, m_ovf);
    @(negedge clk);
  endtask

  initial begin
    rstn = 1'b1; en = 1'b0; soft_clr = 1'b0;
    in_valid = '0; in_data = '0; clr_ovf = '0;
    for (int i = 0; i < NCH; i++) begin m_acc[i] = 0; m_q[i] = 0; end
    m_ptr = 0; m_mode = 0; m_cnt = 0; m_ovf = '0;
    m_ov = 0; m_och = 0; m_oq = 0; m_ores = 0;

    #1 rstn = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_ch", out_ch, 0);
    chk("rst_out_q", out_q, 0);
    chk("rst_out_resid", out_resid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // ch0 constant 3
    en = 1'b1;
    cycle();
    in_valid = 4'b0001; set_ch(0, 3);
    cycle(); chk("p1_q0", out_q, 1); chk("p1_r0", out_resid, 2); chk("p1_ch0", out_ch, 0);
    cycle(); chk("p1_q1", out_q, 1); chk("p1_r1", out_resid, 4);
    cycle(); chk("p1_q2", out_q, 1); chk("p1_r2", out_resid, 6); chk("p1_ovf", ovf, 0);
    in_valid = '0;
    cycle(); chk("p1_idle_valid", out_valid, 0); chk("p1_hold_resid", out_resid, 6);

    // ch2 negative input
    in_valid = 4'b0100; set_ch(2, -5);
    cycle(); chk("p2_ch", out_ch, 2); chk("p2_q", out_q, 0); chk("p2_r", out_resid, -5);
    set_ch(2, 0);
    cycle(); chk("p2_q2", out_q, 0); chk("p2_r2", out_resid, -5);

    // ch1 integrator wrap
    in_valid = 4'b0010; set_ch(1, 511);
    cycle(); chk("p3_q", out_q, 1); chk("p3_r", out_resid, 510);
    cycle(); chk("p3_q2", out_q, 0); chk("p3_r2", out_resid, -3); chk("p3_ovf1", ovf[1], 1);
    in_valid = '0; clr_ovf = 4'b0010;
    cycle(); chk("p3_clr", ovf, 0);
    clr_ovf = '0;

    // all channels contending
    in_valid = '1;
    for (int n = 0; n < 16; n++) begin
      for (int c = 0; c < NCH; c++) set_ch(c, int'($urandom_range(0, 1023)) - 512);
      cycle();
      chk("p4_valid", out_valid, 1);
    end

    // soft clear, including a restart mid-clear
    in_valid = '0; soft_clr = 1'b1;
    cycle(); soft_clr = 1'b0;
    cycle(); cycle();
    soft_clr = 1'b1; cycle(); soft_clr = 1'b0;
    for (int n = 0; n < NCH; n++) begin chk("p5_busy_a", busy, 1); cycle(); end
    in_valid = 4'b0001; set_ch(0, 3);
    cycle(); chk("p5_r0", out_resid, 2);
    set_ch(0, 4);
    cycle(); chk("p5_r1", out_resid, 5);
    set_ch(0, 3); soft_clr = 1'b1;
    cycle(); chk("p5_nogrant", out_valid, 0);
    soft_clr = 1'b0;
    for (int n = 0; n < NCH; n++) begin
      chk("p5_busy_b", busy, 1); chk("p5_ready0", in_ready, 0); cycle();
    end
    chk("p5_busy_done", busy, 0);
    cycle(); chk("p5_ch", out_ch, 0); chk("p5_q", out_q, 1); chk("p5_r2", out_resid, 2);
    set_ch(0, -512);
    cycle(); chk("p5_ovfsub", ovf[0], 1);

    // en low, then raise; set and clear ovf together
    en = 1'b0; in_valid = '0; clr_ovf = '1;
    cycle(); clr_ovf = '0;
    in_valid = 4'b1000; set_ch(3, 511);
    for (int n = 0; n < 2; n++) begin
      cycle(); chk("p6_noready", in_ready, 0); chk("p6_novalid", out_valid, 0);
    end
    en = 1'b1;
    cycle(); chk("p6_wait", out_valid, 0);
    cycle(); chk("p6_valid", out_valid, 1); chk("p6_ch", out_ch, 3); chk("p6_r", out_resid, 510);
    clr_ovf = 4'b1000;
    cycle(); chk("p6_setwins", ovf, 4'b1000); chk("p6_r2", out_resid, -3);
    clr_ovf = '0;

    // randomized traffic
    for (int n = 0; n < 300; n++) begin
      en       = ($urandom_range(0, 9) != 0);
      soft_clr = ($urandom_range(0, 39) == 0);
      in_valid = NCH'($urandom);
      clr_ovf  = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 3) == 0) set_ch(c, ($urandom_range(0, 1) != 0) ? 511 : -512);
        else set_ch(c, int'($urandom_range(0, 1023)) - 512);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
